v_lane_sequencer: RTL and testbench

Sequencing controller for the per-lane vector register file. It accepts one vector operation at a time over a valid/ready handshake. It then steps through the active vector length in beats of `lanes_p` elements, driving per-lane read addresses and enables into the register file. After a fixed datapath latency it replays matching write addresses and enables, then signals completion. It sits between the vector issue logic and the register file / lane ALUs.

---
 rtl/v_lane_sequencer.sv | 149 ++++++++++++++
 tb/tb_v_lane_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/v_lane_sequencer.sv
// Lane sequencer for the vector register file: steps one accepted operation through
// read beats, replays them as writes after latency_p cycles, then pulses done_o.
// Optional stall input enabled by defining V_SEQ_STALL_EN.
module v_lane_sequencer #(
  parameter int unsigned vlen_p    = 8,
  parameter int unsigned lanes_p   = 4,
  parameter int unsigned latency_p = 1,
  localparam int unsigned addr_width_lp  = (vlen_p > 1) ? $clog2(vlen_p) : 1,
  localparam int unsigned vl_width_lp    = $clog2(vlen_p + 1),
  localparam int unsigned beat_width_lp  = ((vlen_p / lanes_p) > 1) ? $clog2(vlen_p / lanes_p) : 1,
  localparam int unsigned drain_width_lp = (latency_p > 1) ? $clog2(latency_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
`ifdef V_SEQ_STALL_EN
  input  logic                                    stall_i,
`endif
  input  logic                                    v_i,
  input  logic [vl_width_lp-1:0]                  vl_i,
  output logic                                    ready_o,
  output logic [lanes_p-1:0][addr_width_lp-1:0]   r_addr_o,
  output logic [lanes_p-1:0]                      r_en_o,
  output logic [lanes_p-1:0][addr_width_lp-1:0]   w_addr_o,
  output logic [lanes_p-1:0]                      w_en_o,
  output logic                                    busy_o,
  output logic                                    done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                                 state_q;
  logic [vl_width_lp-1:0]                 vl_q;
  logic [beat_width_lp-1:0]               k_q;
  logic [drain_width_lp-1:0]              drain_q;
  logic [lanes_p-1:0][addr_width_lp-1:0]  r_addr_q;
  logic [lanes_p-1:0]                     r_en_q;
  logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_pipe_q [latency_p];
  logic [lanes_p-1:0]                     w_en_pipe_q   [latency_p];
  logic                                   ready_q, busy_q, done_q;

  logic                                   stall;
  logic [vl_width_lp-1:0]                 vl_clamp, next_base, beat_base, beat_vl;
  logic [lanes_p-1:0][vl_width_lp-1:0]    elem;
  logic [lanes_p-1:0][addr_width_lp-1:0]  beat_addr;
  logic [lanes_p-1:0]                     beat_en;

`ifdef V_SEQ_STALL_EN
  assign stall = stall_i & busy_q;
`else
  assign stall = 1'b0;
`endif

  assign vl_clamp  = (vl_i > vl_width_lp'(vlen_p)) ? vl_width_lp'(vlen_p) : vl_i;
  assign next_base = vl_width_lp'((32'(k_q) + 32'd1) * lanes_p);

  // Next read beat: beat 0 of the incoming op when idle, else the one after k_q.
  always_comb begin
    beat_base = (state_q == IDLE) ? '0 : next_base;
    beat_vl   = (state_q == IDLE) ? vl_clamp : vl_q;
    elem      = '0;
    beat_en   = '0;
    beat_addr = '0;
    for (int i = 0; i < lanes_p; i++) begin
      elem[i]      = beat_base + vl_width_lp'(i);
      beat_en[i]   = (elem[i] < beat_vl);
      beat_addr[i] = beat_en[i] ? addr_width_lp'(elem[i]) : '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      vl_q     <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      r_addr_q <= '0;
      r_en_q   <= '0;
      for (int j = 0; j < latency_p; j++) begin
        w_addr_pipe_q[j] <= '0;
        w_en_pipe_q[j]   <= '0;
      end
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (!stall) begin
      w_addr_pipe_q[0] <= r_addr_q;
      w_en_pipe_q[0]   <= r_en_q;
      for (int j = 1; j < latency_p; j++) begin
        w_addr_pipe_q[j] <= w_addr_pipe_q[j-1];
        w_en_pipe_q[j]   <= w_en_pipe_q[j-1];
      end
      r_addr_q <= '0;
      r_en_q   <= '0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (v_i) begin
            vl_q    <= vl_clamp;
            k_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (vl_clamp == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= READ;
              r_addr_q <= beat_addr;
              r_en_q   <= beat_en;
            end
          end
        end
        READ: begin
          if (next_base >= vl_q) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            k_q      <= k_q + beat_width_lp'(1);
            r_addr_q <= beat_addr;
            r_en_q   <= beat_en;
          end
        end
        DRAIN: begin
          // Last write beat leaves the pipeline latency_p cycles after the last read.
          if (drain_q == drain_width_lp'(latency_p - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + drain_width_lp'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q & ~stall;
  assign r_addr_o = r_addr_q;
  assign r_en_o   = r_en_q & {lanes_p{~stall}};
  assign w_addr_o = w_addr_pipe_q[latency_p-1];
  assign w_en_o   = w_en_pipe_q[latency_p-1] & {lanes_p{~stall}};

endmodule

// File: tb/tb_v_lane_sequencer.sv
// Bench for v_lane_sequencer: directed operations, per-cycle comparison against a
// timeline model of each accepted operation, plus literal expectations.
module tb_v_lane_sequencer;
  localparam int unsigned VLEN = 8, LANES = 4, LAT = 1, AW = 3, VLW = 4;

  logic clk_i = 1'b0;
  logic reset_i, v_i;
  logic [VLW-1:0] vl_i;
  logic ready_o, busy_o, done_o;
  logic [LANES-1:0][AW-1:0] r_addr_o, w_addr_o;
  logic [LANES-1:0] r_en_o, w_en_o;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, acc_vl = 0;
  bit active = 1'b0;
  logic exp_rdy = 1'b1;
  logic e_rdy, e_done;
  logic [LANES-1:0] e_ren, e_wen;
  logic [LANES-1:0][AW-1:0] e_ra, e_wa;

  always #5 clk_i = ~clk_i;

  v_lane_sequencer #(.vlen_p(VLEN), .lanes_p(LANES), .latency_p(LAT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
`ifdef V_SEQ_STALL_EN
    .stall_i(1'b0),
`endif
    .v_i(v_i), .vl_i(vl_i), .ready_o(ready_o),
    .r_addr_o(r_addr_o), .r_en_o(r_en_o), .w_addr_o(w_addr_o), .w_en_o(w_en_o),
    .busy_o(busy_o), .done_o(done_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Elements k*LANES+i below vl are enabled; disabled lanes read address 0.
  function automatic void beat(input int k, input int vl, output logic [LANES-1:0] en,
                               output logic [LANES-1:0][AW-1:0] ad);
    en = '0;
    ad = '0;
    for (int i = 0; i < LANES; i++)
      if (k * LANES + i < vl) begin
        en[i] = 1'b1;
        ad[i] = AW'(k * LANES + i);
      end
  endfunction

  // Expected outputs in the current cycle, from the accept cycle and vl of the last op.
  function automatic void model_outputs(output logic rdy, output logic dn,
      output logic [LANES-1:0] ren, output logic [LANES-1:0][AW-1:0] ra,
      output logic [LANES-1:0] wen, output logic [LANES-1:0][AW-1:0] wa);
    int t, nb, fin;
    rdy = 1'b1; dn = 1'b0; ren = '0; ra = '0; wen = '0; wa = '0;
    if (active) begin
      t   = cyc - acc_cyc;
      nb  = (acc_vl + LANES - 1) / LANES;
      fin = (acc_vl == 0) ? 1 : nb + LAT + 1;
      if (t >= 1 && t <= fin) rdy = 1'b0;
      if (t == fin) dn = 1'b1;
      if (t >= 1 && t <= nb) beat(t - 1, acc_vl, ren, ra);
      if (t >= 1 + LAT && t <= nb + LAT) beat(t - 1 - LAT, acc_vl, wen, wa);
    end
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) active <= 1'b0;
    else if (v_i && exp_rdy) begin
      active  <= 1'b1;
      acc_cyc <= cyc;
      acc_vl  <= (int'(vl_i) > VLEN) ? VLEN : int'(vl_i);
    end
  end

  always @(negedge clk_i) begin
    model_outputs(e_rdy, e_done, e_ren, e_ra, e_wen, e_wa);
    exp_rdy = e_rdy;
    chk("ready", 32'(ready_o), 32'(e_rdy));
    chk("busy", 32'(busy_o), 32'(!e_rdy));
    chk("done", 32'(done_o), 32'(e_done));
    chk("r_en", 32'(r_en_o), 32'(e_ren));
    chk("r_addr", 32'(r_addr_o), 32'(e_ra));
    chk("w_en", 32'(w_en_o), 32'(e_wen));
    chk("w_addr", 32'(w_addr_o), 32'(e_wa));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready timeout actual=%b required=1", ready_o);
    end
  endtask

  int vl_tab[7] = '{1, 3, 4, 7, 15, 8, 2};

  initial begin
    reset_i = 1'b1; v_i = 1'b0; vl_i = '0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_en", 32'({r_en_o, w_en_o, done_o}), 32'd0);
    chk("rst_addr", 32'({r_addr_o, w_addr_o}), 32'd0);
    repeat (2) step();
    reset_i = 1'b0;
    step();

    // vl=8
    v_i = 1'b1; vl_i = 4'd8; step(); v_i = 1'b0;
    chk("v8_c1_raddr", 32'(r_addr_o), 32'h688);
    chk("v8_c1_ren", 32'(r_en_o), 32'hF);
    step();
    chk("v8_c2_raddr", 32'(r_addr_o), 32'hFAC);
    chk("v8_c2_waddr", 32'(w_addr_o), 32'h688);
    chk("v8_c2_wen", 32'(w_en_o), 32'hF);
    step();
    chk("v8_c3_waddr", 32'(w_addr_o), 32'hFAC);
    chk("v8_c3_ren", 32'(r_en_o), 32'h0);
    step();
    chk("v8_c4_done", 32'(done_o), 32'd1);
    step();
    chk("v8_c5_ready", 32'(ready_o), 32'd1);

    // vl=5
    v_i = 1'b1; vl_i = 4'd5; step(); v_i = 1'b0;
    chk("v5_c1_ren", 32'(r_en_o), 32'hF);
    step();
    chk("v5_c2_ren", 32'(r_en_o), 32'h1);
    chk("v5_c2_raddr", 32'(r_addr_o), 32'h004);
    step();
    chk("v5_c3_wen", 32'(w_en_o), 32'h1);
    chk("v5_c3_waddr", 32'(w_addr_o), 32'h004);
    step();
    chk("v5_c4_done", 32'(done_o), 32'd1);
    step();

    // vl=0, then a second request as soon as ready returns
    v_i = 1'b1; vl_i = 4'd0; step(); v_i = 1'b0;
    chk("v0_c1_done", 32'(done_o), 32'd1);
    chk("v0_c1_en", 32'({r_en_o, w_en_o}), 32'd0);
    step();
    chk("v0_c2_ready", 32'(ready_o), 32'd1);
    v_i = 1'b1; vl_i = 4'd4; step(); v_i = 1'b0;
    chk("v0_next_ren", 32'(r_en_o), 32'hF);
    wait_ready();

    // vl=12 clamps to 8; v_i held high is re-accepted only once ready returns
    v_i = 1'b1; vl_i = 4'd12;
    step();
    chk("v12_c1_raddr", 32'(r_addr_o), 32'h688);
    step();
    chk("v12_c2_raddr", 32'(r_addr_o), 32'hFAC);
    step();
    step();
    chk("v12_c4_done", 32'(done_o), 32'd1);
    step();
    chk("v12_c5_ready", 32'(ready_o), 32'd1);
    step();
    chk("v12_c6_busy", 32'(busy_o), 32'd1);
    chk("v12_c6_ren", 32'(r_en_o), 32'hF);
    v_i = 1'b0;
    wait_ready();

    // Reset mid-operation
    v_i = 1'b1; vl_i = 4'd8; step(); v_i = 1'b0;
    step();
    chk("rmid_c2_ren", 32'(r_en_o), 32'hF);
    #2 reset_i = 1'b1;
    #1;
    chk("rmid_en_async", 32'({r_en_o, w_en_o}), 32'd0);
    chk("rmid_done", 32'(done_o), 32'd0);
    step();
    reset_i = 1'b0;
    step();
    chk("rmid_ready", 32'(ready_o), 32'd1);
    repeat (4) step();

    // Boundary lengths back to back
    foreach (vl_tab[n]) begin
      v_i = 1'b1; vl_i = VLW'(vl_tab[n]); step(); v_i = 1'b0;
      wait_ready();
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
